// File: rtl/instrumented_adder_meter.sv
// Measurement controller for instrumented adders: drives operands into one of
// CHANNELS adders, gates that channel's ring oscillator and counts its edges.
module instrumented_adder_meter #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 24,
  parameter int WIN_W    = 16,
  parameter int SETTLE   = 4,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 active,
  input  logic                 start,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [WIDTH-1:0]     cfg_a,
  input  logic [WIDTH-1:0]     cfg_b,
  input  logic [WIN_W-1:0]     cfg_window,
  input  logic [3:0]           cfg_repeats,
  input  logic [CHANNELS-1:0]  ring_in,
  input  logic [WIDTH:0]       sum_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [CHANNELS-1:0]  ring_en,
  output logic                 busy,
  output logic                 done,
  output logic                 sum_ok,
  output logic [CNT_W+3:0]     count_out,
  output logic                 overflow,
  output logic [2:0]           state_dbg
);

  // Handshake: start is taken only in IDLE with active high; done pulses once
  // per completed measurement and count_out/sum_ok/overflow stay valid until
  // the next accepted start.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CHAN_W:0]  CHAN_LIM  = (CHAN_W+1)'(CHANNELS);
  localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE - 1);
  localparam logic [WIN_W-1:0] DRAIN_LD  = WIN_W'(2);

  state_t              state, state_nxt;
  logic [WIN_W-1:0]    timer;
  logic [3:0]          rep_left;
  logic [CHAN_W-1:0]   chan_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [WIN_W-1:0]    win_q;
  logic [CNT_W-1:0]    win_cnt, win_cnt_nxt;
  logic                sat_hit;
  logic                chan_ok;
  logic                ring_sel;
  logic                sync0, sync1, sync2, edge_q;
  logic [WIN_W-1:0]    win_ld;

  assign chan_ok = ({1'b0, chan_q} < CHAN_LIM);
  assign win_ld  = (win_q == '0) ? '0 : win_q - WIN_W'(1);

  always_comb begin
    ring_sel = 1'b0;
    if (chan_ok) ring_sel = ring_in[chan_q];
  end

  // Two-flop synchroniser plus registered rising-edge detect.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync0  <= ring_sel;
      sync1  <= sync0;
      sync2  <= sync1;
      edge_q <= sync1 & ~sync2;
    end
  end

  always_comb begin
    sat_hit     = edge_q && (win_cnt == '1);
    win_cnt_nxt = win_cnt;
    if (edge_q && !sat_hit) win_cnt_nxt = win_cnt + CNT_W'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!active) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_SETUP;
        S_SETUP: if (timer == '0) state_nxt = S_RUN;
        S_RUN:   if (timer == '0) state_nxt = S_DRAIN;
        S_DRAIN: if (timer == '0) state_nxt = (rep_left == 4'd0) ? S_CHECK : S_RUN;
        S_CHECK: state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !active) begin
      timer     <= '0;
      rep_left  <= '0;
      chan_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      win_q     <= '0;
      win_cnt   <= '0;
      count_out <= '0;
      overflow  <= 1'b0;
      sum_ok    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            chan_q    <= cfg_chan;
            a_q       <= cfg_a;
            b_q       <= cfg_b;
            win_q     <= cfg_window;
            rep_left  <= cfg_repeats;
            timer     <= SETTLE_LD;
            win_cnt   <= '0;
            count_out <= '0;
            overflow  <= 1'b0;
            sum_ok    <= 1'b0;
          end
        end
        S_SETUP: begin
          timer <= (timer == '0) ? win_ld : timer - WIN_W'(1);
        end
        S_RUN: begin
          win_cnt  <= win_cnt_nxt;
          overflow <= overflow | sat_hit;
          timer    <= (timer == '0) ? DRAIN_LD : timer - WIN_W'(1);
        end
        S_DRAIN: begin
          overflow <= overflow | sat_hit;
          if (timer == '0) begin
            count_out <= count_out + {4'b0000, win_cnt_nxt};
            win_cnt   <= '0;
            timer     <= win_ld;
            if (rep_left != 4'd0) rep_left <= rep_left - 4'd1;
          end else begin
            win_cnt <= win_cnt_nxt;
            timer   <= timer - WIN_W'(1);
          end
        end
        S_CHECK: begin
          sum_ok <= (sum_in == ({1'b0, a_q} + {1'b0, b_q}));
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    state_dbg = state;
    a_out     = '0;
    b_out     = '0;
    ring_en   = '0;
    if (busy) begin
      a_out = a_q;
      b_out = b_q;
    end
    if (state == S_RUN && chan_ok) ring_en[chan_q] = 1'b1;
  end

endmodule
